// File: rtl/logic_sweep_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding and
// the reference truth tables of the combinational-logic lab gates.
package logic_sweep_pkg;

    // Raw state codes, kept as plain constants so older code can still compare against them
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        DRIVE = ST_DRIVE,
        CHECK = ST_CHECK,
        DONE  = ST_DONE
    } sweep_state_e;

    // Truth tables, bit i = expected output for in_vec == i (a = in_vec[1], b = in_vec[0])
    localparam logic [3:0] IMPLIC_TT    = 4'b1011;  // a -> b
    localparam logic [3:0] EX_IMPLIC_TT = 4'b0100;  // a & ~b

endpackage

// File: rtl/logic_sweep_ctrl.sv
// Sequential truth-table sweeper: walks every input vector of a small
// combinational gate, holds each one SETTLE cycles, then compares the gate
// output with EXPECT. Reports pass/fail, mismatch count and first failing index.
module logic_sweep_ctrl
    import logic_sweep_pkg::*;
#(
    parameter int                 N_IN   = 2,
    parameter int                 SETTLE = 1,
    parameter logic [2**N_IN-1:0] EXPECT = IMPLIC_TT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop_on_fail,
    output logic [N_IN-1:0] in_vec,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_idx
);

    localparam int              NVEC     = 2**N_IN;
    localparam int              CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NVEC - 1);
    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

    // A zero settle time would sample the gate in the same cycle the vector changes
    if (SETTLE < 1) begin : g_bad_settle
        $error("logic_sweep_ctrl: SETTLE must be >= 1");
    end

    sweep_state_e     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [N_IN-1:0]  idx_nxt;
    logic [N_IN:0]    err_nxt;
    logic             ffv_nxt;
    logic [N_IN-1:0]  ffi_nxt;
    logic             pass_nxt;
    logic             mismatch;
    logic             sweeping_nxt;

    // Next-state and result-update logic; in_vec doubles as the vector index while sweeping
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = in_vec;
        err_nxt   = err_cnt;
        ffv_nxt   = first_fail_valid;
        ffi_nxt   = first_fail_idx;
        pass_nxt  = pass;
        mismatch  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DRIVE;
                    idx_nxt   = '0;
                    cnt_nxt   = CNT_LOAD;
                    err_nxt   = '0;
                    ffv_nxt   = 1'b0;
                    ffi_nxt   = '0;
                    pass_nxt  = 1'b0;
                end
            end
            DRIVE: begin
                // cnt==0 marks the last settle cycle, so the vector is held exactly SETTLE cycles
                if (cnt == '0) begin
                    state_nxt = CHECK;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            CHECK: begin
                mismatch = (dut_out != EXPECT[in_vec]);
                if (mismatch) begin
                    err_nxt = err_cnt + ERR_ONE;
                    if (!first_fail_valid) begin
                        ffv_nxt = 1'b1;
                        ffi_nxt = in_vec;
                    end
                end
                if ((mismatch && stop_on_fail) || (in_vec == LAST_IDX)) begin
                    state_nxt = DONE;
                    pass_nxt  = (err_nxt == '0);
                end else begin
                    state_nxt = DRIVE;
                    idx_nxt   = in_vec + IDX_ONE;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            DONE: begin
                // Always pass through IDLE so a held start leaves one idle cycle between sweeps
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        sweeping_nxt = (state_nxt == DRIVE) || (state_nxt == CHECK);
    end

    // State, settle counter and registered outputs; reset aborts any sweep without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            in_vec           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_cnt          <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            in_vec           <= sweeping_nxt ? idx_nxt : '0;
            busy             <= sweeping_nxt;
            done             <= (state_nxt == DONE);
            pass             <= pass_nxt;
            err_cnt          <= err_nxt;
            first_fail_valid <= ffv_nxt;
            first_fail_idx   <= ffi_nxt;
        end
    end

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Bench for logic_sweep_ctrl: four sweeper instances, each paired with a lab
// gate and a truth table, scored against a behavioural model of the sweep.
module tb_logic_sweep_ctrl;
    import logic_sweep_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] start;
    logic [3:0] stop_on_fail;
    logic [1:0] in_vec [4];
    logic [3:0] gate_out;
    logic [3:0] busy;
    logic [3:0] done;
    logic [3:0] pass;
    logic [2:0] err_cnt [4];
    logic [3:0] ffv;
    logic [1:0] ffi [4];

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         lat;
        logic       pass;
        logic [2:0] err;
        logic       ffv;
        logic [1:0] ffi;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // Lab gates: implication a->b and inverse implication a&~b
    assign gate_out[0] = ~in_vec[0][1] | in_vec[0][0];
    assign gate_out[1] =  in_vec[1][1] & ~in_vec[1][0];
    assign gate_out[2] = ~in_vec[2][1] | in_vec[2][0];
    assign gate_out[3] = ~in_vec[3][1] | in_vec[3][0];

    logic_sweep_ctrl #(.N_IN(2), .SETTLE(1), .EXPECT(IMPLIC_TT)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .stop_on_fail(stop_on_fail[0]),
        .in_vec(in_vec[0]), .dut_out(gate_out[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .err_cnt(err_cnt[0]), .first_fail_valid(ffv[0]), .first_fail_idx(ffi[0]));

    logic_sweep_ctrl #(.N_IN(2), .SETTLE(3), .EXPECT(EX_IMPLIC_TT)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .stop_on_fail(stop_on_fail[1]),
        .in_vec(in_vec[1]), .dut_out(gate_out[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .err_cnt(err_cnt[1]), .first_fail_valid(ffv[1]), .first_fail_idx(ffi[1]));

    logic_sweep_ctrl #(.N_IN(2), .SETTLE(1), .EXPECT(4'b1111)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .stop_on_fail(stop_on_fail[2]),
        .in_vec(in_vec[2]), .dut_out(gate_out[2]), .busy(busy[2]), .done(done[2]),
        .pass(pass[2]), .err_cnt(err_cnt[2]), .first_fail_valid(ffv[2]), .first_fail_idx(ffi[2]));

    logic_sweep_ctrl #(.N_IN(2), .SETTLE(1), .EXPECT(EX_IMPLIC_TT)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start[3]), .stop_on_fail(stop_on_fail[3]),
        .in_vec(in_vec[3]), .dut_out(gate_out[3]), .busy(busy[3]), .done(done[3]),
        .pass(pass[3]), .err_cnt(err_cnt[3]), .first_fail_valid(ffv[3]), .first_fail_idx(ffi[3]));

    function automatic logic [3:0] tt_of(input int u);
        case (u)
            0:       return 4'b1011;
            1:       return 4'b0100;
            2:       return 4'b1111;
            default: return 4'b0100;
        endcase
    endfunction

    function automatic int settle_of(input int u);
        return (u == 1) ? 3 : 1;
    endfunction

    // Gate behaviour from first principles: a = bit 1, b = bit 0
    function automatic logic gate_model(input int u, input int v);
        logic a, b;
        a = v[1];
        b = v[0];
        if (u == 1) return a & ~b;
        return ~a | b;
    endfunction

    function automatic exp_t model(input int u, input logic stop);
        exp_t       e;
        logic [3:0] tt;
        int         n;
        e.err = '0; e.ffv = 1'b0; e.ffi = '0; n = 0;
        tt = tt_of(u);
        for (int i = 0; i < 4; i++) begin
            n = i + 1;
            if (gate_model(u, i) != tt[i]) begin
                e.err = e.err + 3'd1;
                if (!e.ffv) begin
                    e.ffv = 1'b1;
                    e.ffi = 2'(i);
                end
                if (stop) break;
            end
        end
        e.lat  = 1 + n * (settle_of(u) + 1);
        e.pass = (e.err == 3'd0);
        return e;
    endfunction

    // Raise start, record the expected outcome, and return just after the sampling edge k
    task automatic drive_start(input int u, input logic stop);
        @(negedge clk);
        stop_on_fail[u] = stop;
        start[u] = 1'b1;
        sb.push_back(model(u, stop));
        @(posedge clk);
    endtask

    // Follow a sweep to its done pulse, then pop and score the expected outcome
    task automatic await_and_score(input int u, input bit hold, input int restart_at, input bit chk_vec);
        int         n;
        bit         seen;
        exp_t       e;
        logic [1:0] ev;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (!hold) start[u] = (restart_at > 0) && (n == restart_at);
            if (chk_vec && n <= 8) begin
                ev = 2'((n - 1) / 2);
                tests++;
                if (in_vec[u] !== ev || busy[u] !== 1'b1) begin
                    fails++;
                    $display("FAIL vec_step c%0d: in_vec=%0d busy=%b, want in_vec=%0d busy=1", n, in_vec[u], busy[u], ev);
                end
            end
            if (done[u] === 1'b1) seen = 1'b1;
        end
        e = sb.pop_front();
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL done_timeout u%0d: no done within %0d cycles, want %0d", u, n, e.lat);
        end else if (n != e.lat) begin
            fails++;
            $display("FAIL done_latency u%0d: got k+%0d want k+%0d", u, n, e.lat);
        end
        tests++;
        if (pass[u] !== e.pass || err_cnt[u] !== e.err || ffv[u] !== e.ffv || busy[u] !== 1'b0) begin
            fails++;
            $display("FAIL results u%0d: pass=%b err=%0d ffv=%b busy=%b, want pass=%b err=%0d ffv=%b busy=0",
                     u, pass[u], err_cnt[u], ffv[u], busy[u], e.pass, e.err, e.ffv);
        end
        if (e.ffv) begin
            tests++;
            if (ffi[u] !== e.ffi) begin
                fails++;
                $display("FAIL first_fail_idx u%0d: got %0d want %0d", u, ffi[u], e.ffi);
            end
        end
        @(negedge clk);
        tests++;
        if (done[u] !== 1'b0 || busy[u] !== 1'b0 || in_vec[u] !== 2'd0 || err_cnt[u] !== e.err || pass[u] !== e.pass) begin
            fails++;
            $display("FAIL after_done u%0d: done=%b busy=%b in_vec=%0d err=%0d pass=%b, want 0 0 0 %0d %b",
                     u, done[u], busy[u], in_vec[u], err_cnt[u], pass[u], e.err, e.pass);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = '0;
        stop_on_fail = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            tests++;
            if (in_vec[u] !== 2'd0 || busy[u] !== 1'b0 || done[u] !== 1'b0 || pass[u] !== 1'b0 ||
                err_cnt[u] !== 3'd0 || ffv[u] !== 1'b0 || ffi[u] !== 2'd0) begin
                fails++;
                $display("FAIL reset_state u%0d: in_vec=%0d busy=%b done=%b pass=%b err=%0d ffv=%b ffi=%0d, want all 0",
                         u, in_vec[u], busy[u], done[u], pass[u], err_cnt[u], ffv[u], ffi[u]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_implication();
        drive_start(0, 1'b0);
        await_and_score(0, 1'b0, 0, 1'b1);
    endtask

    task automatic test_inverse_settle3();
        drive_start(1, 1'b0);
        await_and_score(1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_all_ones();
        drive_start(2, 1'b0);
        await_and_score(2, 1'b0, 0, 1'b0);
        drive_start(2, 1'b1);
        await_and_score(2, 1'b0, 0, 1'b0);
    endtask

    task automatic test_wrong_table();
        drive_start(3, 1'b0);
        await_and_score(3, 1'b0, 0, 1'b0);
    endtask

    task automatic test_mid_restart();
        drive_start(0, 1'b0);
        await_and_score(0, 1'b0, 4, 1'b1);
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
                fails++;
                $display("FAIL restart_ignored: busy=%b done=%b, want 0 0", busy[0], done[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive_start(0, 1'b0);
        await_and_score(0, 1'b1, 0, 1'b0);
        // The sweep restarted by the held start is sampled on the next edge
        sb.push_back(model(0, 1'b0));
        @(posedge clk);
        await_and_score(0, 1'b0, 0, 1'b1);
    endtask

    task automatic test_async_reset();
        bit got_done;
        drive_start(0, 1'b0);
        repeat (5) begin
            @(negedge clk);
            start[0] = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (in_vec[0] !== 2'd0 || busy[0] !== 1'b0 || done[0] !== 1'b0 || pass[0] !== 1'b0 ||
            err_cnt[0] !== 3'd0 || ffv[0] !== 1'b0 || ffi[0] !== 2'd0) begin
            fails++;
            $display("FAIL async_reset: in_vec=%0d busy=%b done=%b pass=%b err=%0d ffv=%b ffi=%0d, want all 0",
                     in_vec[0], busy[0], done[0], pass[0], err_cnt[0], ffv[0], ffi[0]);
        end
        void'(sb.pop_front());
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        got_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done[0] === 1'b1 || busy[0] === 1'b1) got_done = 1'b1;
        end
        tests++;
        if (got_done) begin
            fails++;
            $display("FAIL aborted_sweep: activity seen after reset=1, want none");
        end
        drive_start(0, 1'b0);
        await_and_score(0, 1'b0, 0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_implication();
        test_inverse_settle3();
        test_all_ones();
        test_wrong_table();
        test_mid_restart();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
